uart_tx_serializer: RTL and testbench

- Serial transmit engine for the APB UART.
- Accepts one parallel character per handshake and shifts it out on SOUT as start / 5-8 data bits (LSB first) / optional parity / 1, 1.5 or 2 stop bits.
- Bit timing is derived from the oversampling baud clock-enable produced by the baud generator.
- Sits between the TX FIFO / holding register and the SOUT pin. It is the transmit-side counterpart of the receive path that uses the generic counter library.

---
 rtl/uart_tx_serializer_if.sv | 41 ++++
 rtl/uart_tx_serializer.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if
// Character hand-off between the TX FIFO / holding register (master) and the
// serial transmit engine (slave).
//
// Handshake: txstart is the valid strobe and !busy is the ready condition. A
// character (din plus the line-format fields) is taken on a rising clock edge
// where txstart=1 and busy=0. While busy=1, txstart is ignored and nothing is
// queued. txfinished pulses high for one cycle during the last cycle of the
// frame. busy is still high in that cycle.
//
// Signals:
//   txstart    master->slave  request to send din
//   din[7:0]   master->slave  character; bits above the word length are unused
//   wls[1:0]   master->slave  word length 00=5 .. 11=8 bits
//   stb        master->slave  0 = 1 stop bit, 1 = 2 stop bits (1.5 for 5-bit words)
//   pen        master->slave  parity enable
//   eps        master->slave  even parity select
//   sp         master->slave  stick parity
//   busy       slave->master  frame in progress
//   txfinished slave->master  one-cycle end-of-frame pulse
interface uart_tx_serializer_if;
  logic       txstart;
  logic [7:0] din;
  logic [1:0] wls;
  logic       stb;
  logic       pen;
  logic       eps;
  logic       sp;
  logic       busy;
  logic       txfinished;

  modport master (
    output txstart, din, wls, stb, pen, eps, sp,
    input  busy, txfinished
  );

  modport slave (
    input  txstart, din, wls, stb, pen, eps, sp,
    output busy, txfinished
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Serial transmit engine for the APB UART. It takes one character per
// handshake and shifts it out on sout as a frame:
//   start bit, 5-8 data bits (LSB first), optional parity, then 1, 1.5 or 2 stop bits.
// Each serial bit lasts OVERSAMPLE pulses of baudce. OVERSAMPLE must be even
// and at least 4.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   clear      synchronous abort back to idle; takes priority over txstart
//   baudce     single-cycle oversampling baud enable
//   bc         break control; forces sout low while the FSM keeps running
//   sout       serial data out, registered, idles high
//   dbg_state  current FSM state (state_t encoding), for observation
//   tx         character handshake and line format (slave side)
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 baudce,
  input  logic                 bc,
  output logic                 sout,
  output logic [2:0]           dbg_state,
  uart_tx_serializer_if.slave  tx
);

  localparam int CW = $clog2(OVERSAMPLE) + 1;

  // Last counter value of each period type. The stop period is counted as
  // one long period, so the counter must be able to reach 2*OVERSAMPLE-1.
  localparam logic [CW-1:0] BIT_LAST    = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] STOP15_LAST = CW'((3 * OVERSAMPLE) / 2 - 1);
  localparam logic [CW-1:0] STOP2_LAST  = CW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] os_q, os_d;
  logic [2:0]    bit_q, bit_d;

  // Frame configuration captured at acceptance and held for the whole frame.
  logic [7:0]    data_q;
  logic [1:0]    wls_q;
  logic          stb_q, pen_q, eps_q, sp_q;

  logic          sout_q, busy_q;
  logic          capture, fin;
  logic          period_end, last_data;
  logic [CW-1:0] stop_last;
  logic [7:0]    data_mask;
  logic          data_xor, parity_bit, sout_nominal;

  // Stop length: one bit, two bits, or 1.5 bits when 2 stop bits are
  // selected for a 5-bit word.
  always_comb begin
    stop_last = BIT_LAST;
    if (stb_q) stop_last = (wls_q == 2'b00) ? STOP15_LAST : STOP2_LAST;
  end

  assign period_end = (state_q == ST_STOP) ? (os_q == stop_last) : (os_q == BIT_LAST);
  assign last_data  = (bit_q == ({1'b0, wls_q} + 3'd4));

  // ~wls equals 3-wls for a 2-bit field, so this keeps the low 5+wls bits.
  assign data_mask  = 8'hFF >> {1'b0, ~wls_q};
  assign data_xor   = ^(data_q & data_mask);
  assign parity_bit = sp_q ? ~eps_q : (eps_q ? data_xor : ~data_xor);

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    capture = 1'b0;
    fin     = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      os_d    = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tx.txstart) begin
            capture = 1'b1;
            os_d    = '0;
            bit_d   = '0;
            state_d = ST_START;
          end
        end
        default: begin
          if (baudce) begin
            if (period_end) begin
              os_d = '0;
              case (state_q)
                ST_START: state_d = ST_DATA;
                ST_DATA: begin
                  if (last_data) begin
                    bit_d   = '0;
                    state_d = pen_q ? ST_PARITY : ST_STOP;
                  end else begin
                    bit_d = bit_q + 3'd1;
                  end
                end
                ST_PARITY: state_d = ST_STOP;
                ST_STOP: begin
                  state_d = ST_IDLE;
                  fin     = 1'b1;
                end
                default: state_d = ST_IDLE;
              endcase
            end else begin
              os_d = os_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Line level for the state being entered. This makes the registered
  // sout line up with the state register.
  always_comb begin
    sout_nominal = 1'b1;
    case (state_d)
      ST_START:  sout_nominal = 1'b0;
      ST_DATA:   sout_nominal = data_q[bit_d];
      ST_PARITY: sout_nominal = parity_bit;
      default:   sout_nominal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      data_q  <= '0;
      wls_q   <= '0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      sp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      // Break only masks the pin. The frame timing underneath is unaffected.
      sout_q  <= bc ? 1'b0 : sout_nominal;
      busy_q  <= (state_d != ST_IDLE);
      if (capture) begin
        data_q <= tx.din;
        wls_q  <= tx.wls;
        stb_q  <= tx.stb;
        pen_q  <= tx.pen;
        eps_q  <= tx.eps;
        sp_q   <= tx.sp;
      end
    end
  end

  assign sout          = sout_q;
  assign tx.busy       = busy_q;
  assign tx.txfinished = fin;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       baudce = 1'b1;
  logic       bc = 1'b0;
  logic       sout;
  logic [2:0] dbg_state;

  uart_tx_serializer_if tx_if();

  uart_tx_serializer #(.OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .baudce    (baudce),
    .bc        (bc),
    .sout      (sout),
    .dbg_state (dbg_state),
    .tx        (tx_if)
  );

  always #5 clk = ~clk;

  // Baud enable: tied high (div 1), or one pulse every baud_div cycles,
  // or forced low while baud_hold is set.
  int   baud_div = 1;
  int   bcnt = 0;
  logic baud_hold = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (baud_hold) baudce = 1'b0;
    else if (baud_div <= 1) baudce = 1'b1;
    else begin
      baudce = (bcnt == 0);
      bcnt   = (bcnt + 1) % baud_div;
    end
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic sout_log [0:2047];
  logic busy_log [0:2047];
  logic fin_log  [0:2047];

  // Per-cycle schedule applied by capture(); -1 disables an entry.
  int         inj_a, inj_b, clr_cyc, bc_on, bc_off, hold_on, hold_off, scramble_cyc;
  logic [7:0] din_a, din_b;

  task automatic reset_sched();
    inj_a = -1; inj_b = -1; clr_cyc = -1; bc_on = -1; bc_off = -1;
    hold_on = -1; hold_off = -1; scramble_cyc = -1;
    din_a = 8'h00; din_b = 8'h00;
  endtask

  // ---------------- driver tasks ----------------
  // Raise txstart in a cycle that carries a baud pulse. The acceptance edge
  // ends that cycle, and the cycle after it is frame cycle 0.
  task automatic start_frame(input logic [7:0] d, input logic [1:0] w,
                             input logic s_stb, input logic s_pen,
                             input logic s_eps, input logic s_sp);
    int waited;
    waited = 0;
    @(negedge clk);
    while (baudce !== 1'b1 && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    if (baudce !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL start_frame: baudce=%b after 16 cycles, expected 1", baudce);
    end
    tx_if.din = d; tx_if.wls = w; tx_if.stb = s_stb; tx_if.pen = s_pen;
    tx_if.eps = s_eps; tx_if.sp = s_sp;
    tx_if.txstart = 1'b1;
  endtask

  // Log outputs for n cycles, sampling at the falling edge. After each sample,
  // apply the inputs that the next rising edge should see.
  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      sout_log[c] = sout;
      busy_log[c] = tx_if.busy;
      fin_log[c]  = tx_if.txfinished;
      tx_if.txstart = (c == inj_a) || (c == inj_b);
      if (c == inj_a) tx_if.din = din_a;
      if (c == inj_b) tx_if.din = din_b;
      clear     = (c == clr_cyc);
      bc        = (c >= bc_on) && (c < bc_off);
      baud_hold = (c >= hold_on) && (c < hold_off);
      if (c == scramble_cyc) begin
        tx_if.din = 8'h00; tx_if.wls = 2'b00; tx_if.pen = 1'b1;
        tx_if.stb = 1'b1;  tx_if.eps = 1'b1;  tx_if.sp = 1'b1;
      end
    end
    tx_if.txstart = 1'b0; clear = 1'b0; bc = 1'b0; baud_hold = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (sout !== 1'b1 || tx_if.busy !== 1'b0 || tx_if.txfinished !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: sout=%b busy=%b fin=%b expected 1 0 0", sout, tx_if.busy, tx_if.txfinished);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d expected 0", dbg_state);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sout !== 1'b1 || tx_if.busy !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle_after_release: sout=%b busy=%b state=%0d expected 1 0 0", sout, tx_if.busy, dbg_state);
    end
  endtask

  // 8N1 frame of 0xA5. The inputs are scrambled at cycle 5 to show that the
  // captured configuration is used.
  task automatic test_basic();
    logic [9:0] fr;
    int bad, nb, nf, fat;
    fr = 10'b1101001010;  // 0 1 0 1 0 0 1 0 1 1, first bit in bit 0
    reset_sched();
    scramble_cyc = 5;
    start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(161);
    bad = -1;
    for (int c = 0; c < 160; c++) if (bad < 0 && sout_log[c] !== fr[c / 16]) bad = c;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL basic_sout: cycle %0d sout=%b expected %b", bad, sout_log[bad], fr[bad / 16]);
    end
    nb = 0; nf = 0; fat = -1;
    for (int c = 0; c < 161; c++) begin
      if (busy_log[c] === 1'b1) nb++;
      if (fin_log[c] === 1'b1) begin nf++; fat = c; end
    end
    checks++;
    if (nb !== 160 || busy_log[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy cycles=%0d first=%b expected 160 and 1", nb, busy_log[0]);
    end
    checks++;
    if (nf !== 1 || fat !== 159) begin
      errors++;
      $display("FAIL basic_txfinished: pulses=%0d last at %0d expected 1 at 159", nf, fat);
    end
    checks++;
    if (sout_log[160] !== 1'b1 || busy_log[160] !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: sout=%b busy=%b expected 1 0", sout_log[160], busy_log[160]);
    end
  endtask

  // Parity variants with 2 stop bits: 1.5 stop bits for a 5-bit word and
  // 2 stop bits for a 7-bit word.
  task automatic test_parity();
    logic [7:0] d;
    logic [1:0] w;
    logic e, s, lvl, par, ex;
    int nbits, len, bad, nb, nf, fat;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin d = 8'hFF; w = 2'b00; e = 1'b1; s = 1'b0; lvl = 1'b1; nbits = 5; par = 1'b1; len = 136; end
        1:       begin d = 8'hFF; w = 2'b00; e = 1'b0; s = 1'b0; lvl = 1'b1; nbits = 5; par = 1'b0; len = 136; end
        2:       begin d = 8'h00; w = 2'b10; e = 1'b0; s = 1'b1; lvl = 1'b0; nbits = 7; par = 1'b1; len = 176; end
        default: begin d = 8'h00; w = 2'b10; e = 1'b1; s = 1'b1; lvl = 1'b0; nbits = 7; par = 1'b0; len = 176; end
      endcase
      reset_sched();
      start_frame(d, w, 1'b1, 1'b1, e, s);
      capture(len + 1);
      bad = -1; ex = 1'b1;
      for (int c = 0; c <= len; c++) begin
        if (c < 16) ex = 1'b0;
        else if (c < 16 + 16 * nbits) ex = lvl;
        else if (c < 32 + 16 * nbits) ex = par;
        else ex = 1'b1;
        if (bad < 0 && sout_log[c] !== ex) bad = c;
      end
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL parity_sout[%0d]: cycle %0d sout=%b", i, bad, sout_log[bad]);
      end
      nb = 0; nf = 0; fat = -1;
      for (int c = 0; c <= len; c++) begin
        if (busy_log[c] === 1'b1) nb++;
        if (fin_log[c] === 1'b1) begin nf++; fat = c; end
      end
      checks++;
      if (nf !== 1 || fat !== len - 1) begin
        errors++;
        $display("FAIL parity_txfinished[%0d]: pulses=%0d at %0d expected 1 at %0d", i, nf, fat, len - 1);
      end
      checks++;
      if (nb !== len) begin
        errors++;
        $display("FAIL parity_busy[%0d]: busy cycles=%0d expected %0d", i, nb, len);
      end
    end
  endtask

  // baudce every 4th cycle. A txstart in the middle of the frame is ignored.
  // A txstart in the cycle after txfinished starts 0x81 at once.
  task automatic test_back_to_back();
    logic [9:0] fr1, fr2;
    logic ex;
    int bad, k, nf, f1, f2, bad_busy;
    fr1 = 10'b1001111000;  // 0x3C frame
    fr2 = 10'b1100000010;  // 0x81 frame
    reset_sched();
    baud_div = 4;
    inj_a = 200; din_a = 8'hFF;
    inj_b = 640; din_b = 8'h81;
    start_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(1281);
    baud_div = 1;
    bad = -1; ex = 1'b1;
    for (int c = 0; c < 1281; c++) begin
      if (c < 640) ex = fr1[c / 64];
      else if (c == 640 || c == 1280) ex = 1'b1;
      else begin
        k = c - 641;
        ex = (k < 63) ? fr2[0] : fr2[1 + (k - 63) / 64];
      end
      if (bad < 0 && sout_log[c] !== ex) bad = c;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL b2b_sout: cycle %0d sout=%b expected %b", bad, sout_log[bad], ex);
    end
    nf = 0; f1 = -1; f2 = -1; bad_busy = -1;
    for (int c = 0; c < 1281; c++) begin
      if (fin_log[c] === 1'b1) begin
        nf++;
        if (f1 < 0) f1 = c; else f2 = c;
      end
      if (bad_busy < 0 && busy_log[c] !== ((c == 640 || c == 1280) ? 1'b0 : 1'b1)) bad_busy = c;
    end
    checks++;
    if (nf !== 2 || f1 !== 639 || f2 !== 1279) begin
      errors++;
      $display("FAIL b2b_txfinished: pulses=%0d at %0d,%0d expected 2 at 639,1279", nf, f1, f2);
    end
    checks++;
    if (bad_busy >= 0) begin
      errors++;
      $display("FAIL b2b_busy: cycle %0d busy=%b", bad_busy, busy_log[bad_busy]);
    end
  endtask

  // clear is asserted in cycle 70, which falls in data bit 3 (cycles 64-79).
  task automatic test_clear();
    logic [9:0] fr;
    int bad, nf, fat;
    fr = 10'b1101001010;
    reset_sched();
    clr_cyc = 70;
    start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(100);
    bad = -1;
    for (int c = 0; c < 100; c++)
      if (bad < 0 && sout_log[c] !== ((c <= 70) ? fr[c / 16] : 1'b1)) bad = c;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL clear_sout: cycle %0d sout=%b", bad, sout_log[bad]);
    end
    checks++;
    if (busy_log[70] !== 1'b1 || busy_log[71] !== 1'b0) begin
      errors++;
      $display("FAIL clear_busy: busy[70]=%b busy[71]=%b expected 1 0", busy_log[70], busy_log[71]);
    end
    nf = 0;
    for (int c = 0; c < 100; c++) if (fin_log[c] === 1'b1) nf++;
    checks++;
    if (nf !== 0) begin
      errors++;
      $display("FAIL clear_no_txfinished: pulses=%0d expected 0", nf);
    end
    reset_sched();
    start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(161);
    bad = -1; nf = 0; fat = -1;
    for (int c = 0; c < 160; c++) if (bad < 0 && sout_log[c] !== fr[c / 16]) bad = c;
    for (int c = 0; c < 161; c++) if (fin_log[c] === 1'b1) begin nf++; fat = c; end
    checks++;
    if (bad >= 0 || nf !== 1 || fat !== 159) begin
      errors++;
      $display("FAIL clear_refire: first bad cycle %0d, pulses=%0d at %0d expected -1, 1 at 159", bad, nf, fat);
    end
  endtask

  // bc is high in cycles 20-99, so sout is forced low in cycles 21-100.
  task automatic test_break();
    logic [9:0] fr;
    logic ex;
    int bad, nf, fat;
    fr = 10'b1101001010;
    reset_sched();
    bc_on = 20; bc_off = 100;
    start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(161);
    bad = -1; ex = 1'b1;
    for (int c = 0; c < 161; c++) begin
      if (c >= 21 && c <= 100) ex = 1'b0;
      else if (c < 160) ex = fr[c / 16];
      else ex = 1'b1;
      if (bad < 0 && sout_log[c] !== ex) bad = c;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL break_sout: cycle %0d sout=%b expected %b", bad, sout_log[bad], ex);
    end
    nf = 0; fat = -1;
    for (int c = 0; c < 161; c++) if (fin_log[c] === 1'b1) begin nf++; fat = c; end
    checks++;
    if (nf !== 1 || fat !== 159) begin
      errors++;
      $display("FAIL break_txfinished: pulses=%0d at %0d expected 1 at 159", nf, fat);
    end
  endtask

  // baudce is low in cycles 21-70, so the frame stretches by 50 cycles.
  task automatic test_baud_hold();
    logic [9:0] fr;
    logic ex;
    int bad, nf, fat;
    fr = 10'b1101001010;
    reset_sched();
    hold_on = 20; hold_off = 70;
    start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(211);
    bad = -1; ex = 1'b1;
    for (int c = 0; c < 211; c++) begin
      if (c <= 20) ex = fr[c / 16];
      else if (c <= 70) ex = fr[1];
      else if (c < 210) ex = fr[(c - 50) / 16];
      else ex = 1'b1;
      if (bad < 0 && sout_log[c] !== ex) bad = c;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL hold_sout: cycle %0d sout=%b expected %b", bad, sout_log[bad], ex);
    end
    nf = 0; fat = -1;
    for (int c = 0; c < 211; c++) if (fin_log[c] === 1'b1) begin nf++; fat = c; end
    checks++;
    if (nf !== 1 || fat !== 209) begin
      errors++;
      $display("FAIL hold_txfinished: pulses=%0d at %0d expected 1 at 209", nf, fat);
    end
  endtask

  // Reset asserted mid-frame, away from any clock edge.
  task automatic test_async_reset();
    int bad;
    reset_sched();
    start_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(50);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (sout !== 1'b1 || tx_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_outputs: sout=%b busy=%b expected 1 0", sout, tx_if.busy);
    end
    checks++;
    if (dbg_state !== 3'd0 || tx_if.txfinished !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_state: state=%0d fin=%b expected 0 0", dbg_state, tx_if.txfinished);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    capture(20);
    bad = -1;
    for (int c = 0; c < 20; c++)
      if (bad < 0 && (sout_log[c] !== 1'b1 || busy_log[c] !== 1'b0 || fin_log[c] !== 1'b0)) bad = c;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL async_reset_idle: cycle %0d sout=%b busy=%b fin=%b expected 1 0 0",
               bad, sout_log[bad], busy_log[bad], fin_log[bad]);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tx_if.txstart = 1'b0; tx_if.din = 8'h00; tx_if.wls = 2'b11;
    tx_if.stb = 1'b0; tx_if.pen = 1'b0; tx_if.eps = 1'b0; tx_if.sp = 1'b0;
    reset_sched();
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_clear();
    test_break();
    test_baud_hold();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
